// File: rtl/iter_sort_pkg.sv
// Shared types and constants for the iterative odd-even transposition sorter.
package iter_sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ASCEND  = 1'b0;
    localparam logic DESCEND = 1'b1;

endpackage

// File: rtl/cmp_swap_unit.sv
// Combinational compare-exchange cell: out_lo is the value that belongs at the lower index.
module cmp_swap_unit
    import iter_sort_pkg::*;
#(
    parameter int p_nbits = 8
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               mode,
    output logic [p_nbits-1:0] out_lo,
    output logic [p_nbits-1:0] out_hi
);

    logic swap;

    // Strict compares so equal values never move.
    always_comb begin
        if (mode == DESCEND) begin
            swap = (in0 < in1);
        end else begin
            swap = (in0 > in1);
        end
        out_lo = swap ? in1 : in0;
        out_hi = swap ? in0 : in1;
    end

endmodule

// File: rtl/iter_sort_unit.sv
// Iterative sorter: one odd-even transposition phase per cycle, p_nelems phases per message.
module iter_sort_unit
    import iter_sort_pkg::*;
#(
    parameter int p_nbits  = 8,
    parameter int p_nelems = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_nelems*p_nbits-1:0] in_msg,
    input  logic                        in_mode,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [p_nelems*p_nbits-1:0] out_msg
);

    localparam int c_cnt_w = (p_nelems > 2) ? $clog2(p_nelems) : 1;

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 mode_q;
    logic [c_cnt_w-1:0]   phase;
    logic [p_nbits-1:0]   elems    [p_nelems];
    logic [p_nbits-1:0]   even_res [p_nelems];
    logic [p_nbits-1:0]   odd_res  [p_nelems];

    for (genvar g = 0; g < p_nelems / 2; g++) begin : g_even
        cmp_swap_unit #(.p_nbits(p_nbits)) u_cs (
            .in0    (elems[2*g]),
            .in1    (elems[2*g+1]),
            .mode   (mode_q),
            .out_lo (even_res[2*g]),
            .out_hi (even_res[2*g+1])
        );
    end

    for (genvar g = 0; g < p_nelems / 2 - 1; g++) begin : g_odd
        cmp_swap_unit #(.p_nbits(p_nbits)) u_cs (
            .in0    (elems[2*g+1]),
            .in1    (elems[2*g+2]),
            .mode   (mode_q),
            .out_lo (odd_res[2*g+1]),
            .out_hi (odd_res[2*g+2])
        );
    end

    // End elements have no partner in an odd phase.
    assign odd_res[0]          = elems[0];
    assign odd_res[p_nelems-1] = elems[p_nelems-1];

    for (genvar g = 0; g < p_nelems; g++) begin : g_out
        assign out_msg[g*p_nbits +: p_nbits] = elems[g];
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_val   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    accept    = 1'b1;
                    state_nxt = SORT;
                end
            end
            SORT: begin
                if (phase == c_cnt_w'(p_nelems - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mode_q <= ASCEND;
            phase  <= '0;
            for (int i = 0; i < p_nelems; i++) begin
                elems[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                mode_q <= in_mode;
                phase  <= '0;
                for (int i = 0; i < p_nelems; i++) begin
                    elems[i] <= in_msg[i*p_nbits +: p_nbits];
                end
            end else if (state == SORT) begin
                phase <= phase + 1'b1;
                for (int i = 0; i < p_nelems; i++) begin
                    elems[i] <= phase[0] ? odd_res[i] : even_res[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_sort_unit.sv
// Self-checking bench for iter_sort_unit against a plain selection-sort reference.
module tb_iter_sort_unit;

    localparam int NB = 8;
    localparam int NE = 4;
    localparam int MW = NB * NE;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_val;
    logic          in_rdy;
    logic [MW-1:0] in_msg;
    logic          in_mode;
    logic          out_val;
    logic          out_rdy;
    logic [MW-1:0] out_msg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iter_sort_unit #(.p_nbits(NB), .p_nelems(NE)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg  (in_msg),
        .in_mode (in_mode),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    function automatic logic [MW-1:0] pack4(int a, int b, int c, int d);
        return {NB'(d), NB'(c), NB'(b), NB'(a)};
    endfunction

    function automatic logic [MW-1:0] ref_sort(logic [MW-1:0] m, logic desc);
        int v [NE];
        int t;
        logic [MW-1:0] r;
        for (int i = 0; i < NE; i++) v[i] = int'(m[i*NB +: NB]);
        for (int i = 0; i < NE; i++) begin
            for (int j = i + 1; j < NE; j++) begin
                if (desc ? (v[j] > v[i]) : (v[j] < v[i])) begin
                    t = v[i]; v[i] = v[j]; v[j] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < NE; i++) r[i*NB +: NB] = NB'(v[i]);
        return r;
    endfunction

    task automatic chk(string tag, logic [MW-1:0] obs, logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for out_val after an accept edge; returns cycles counted from accept (T+1 = 1).
    task automatic wait_out(output int c);
        c = 0;
        while (c < 20) begin
            @(negedge clk);
            c++;
            if (out_val) break;
        end
    endtask

    task automatic run_msg(string tag, logic [MW-1:0] m, logic md, int hold);
        int c;
        logic [MW-1:0] exp;
        exp = ref_sort(m, md);
        c = 0;
        while (!in_rdy && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_rdy"}, MW'(in_rdy), MW'(1));
        out_rdy = (hold == 0);
        in_val  = 1'b1;
        in_msg  = m;
        in_mode = md;
        @(posedge clk);
        #1;
        in_val  = 1'b0;
        in_msg  = $urandom;
        in_mode = 1'($urandom);
        wait_out(c);
        chk({tag, "_lat"}, MW'(c), MW'(NE + 1));
        chk({tag, "_res"}, out_msg, exp);
        for (int h = 0; h < hold; h++) begin
            in_msg = $urandom;
            @(negedge clk);
            chk({tag, "_hold_val"}, MW'(out_val), MW'(1));
            chk({tag, "_hold_msg"}, out_msg, exp);
            chk({tag, "_hold_rdy"}, MW'(in_rdy), MW'(0));
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_rdy"}, MW'(in_rdy), MW'(1));
        chk({tag, "_idle_val"}, MW'(out_val), MW'(0));
    endtask

    initial begin
        int c;
        logic [MW-1:0] ma, mb, rm;
        logic rmd;

        reset   = 1'b1;
        in_val  = 1'b0;
        in_msg  = '0;
        in_mode = 1'b0;
        out_rdy = 1'b1;
        #1;
        chk("rst_rdy", MW'(in_rdy), MW'(1));
        chk("rst_val", MW'(out_val), MW'(0));
        chk("rst_msg", out_msg, '0);
        #12;
        reset = 1'b0;

        run_msg("asc", pack4(3, 1, 4, 2), 1'b0, 0);
        run_msg("desc", pack4(3, 1, 4, 2), 1'b1, 0);
        run_msg("edge", pack4(255, 0, 255, 0), 1'b0, 0);
        run_msg("equal", pack4(7, 7, 7, 7), 1'b1, 0);
        run_msg("stall", pack4(10, 200, 3, 99), 1'b1, 3);

        // Reset in SORT phase 2 aborts the message.
        in_val  = 1'b1;
        in_msg  = pack4(50, 40, 30, 20);
        in_mode = 1'b0;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_val", MW'(out_val), MW'(0));
        chk("midrst_rdy", MW'(in_rdy), MW'(1));
        chk("midrst_msg", out_msg, '0);
        #1;
        reset = 1'b0;
        run_msg("after_rst", pack4(9, 8, 7, 6), 1'b0, 0);

        // Back-to-back with in_val held high.
        ma = pack4(17, 3, 88, 42);
        mb = pack4(5, 250, 5, 100);
        out_rdy = 1'b1;
        in_val  = 1'b1;
        in_msg  = ma;
        in_mode = 1'b0;
        @(posedge clk);
        #1;
        in_msg  = mb;
        in_mode = 1'b1;
        wait_out(c);
        chk("b2b_a_lat", MW'(c), MW'(NE + 1));
        chk("b2b_a_res", out_msg, ref_sort(ma, 1'b0));
        chk("b2b_a_rdy", MW'(in_rdy), MW'(0));
        @(negedge clk);
        chk("b2b_b_accept_rdy", MW'(in_rdy), MW'(1));
        @(posedge clk);
        #1;
        in_val = 1'b0;
        wait_out(c);
        chk("b2b_b_lat", MW'(c), MW'(NE + 1));
        chk("b2b_b_res", out_msg, ref_sort(mb, 1'b1));
        @(negedge clk);
        chk("b2b_idle_rdy", MW'(in_rdy), MW'(1));

        for (int k = 0; k < 12; k++) begin
            rm  = $urandom;
            if (k % 4 == 0) rm[15:8] = rm[7:0];
            rmd = 1'($urandom);
            run_msg("rand", rm, rmd, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_sort_unit.md
ITER_SORT_UNIT -- requirements
Module: iter_sort_unit

Interface
REQ-001 Parameter p_nbits, default 8, width of one element (>=1).
REQ-002 Parameter p_nelems, default 4, element count per message (even, >=2).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_val  input  1  input message valid.
REQ-006 in_rdy  output  1  block can accept a message.
REQ-007 in_msg  input  p_nelems*p_nbits  unsorted elements; element i at bits [i*p_nbits +: p_nbits].
REQ-008 in_mode  input  1  0 = ascending, 1 = descending; sampled with in_msg.
REQ-009 out_val  output  1  sorted message valid.
REQ-010 out_rdy  input  1  consumer can accept.
REQ-011 out_msg  output  p_nelems*p_nbits  sorted elements, same packing as in_msg.

Function
REQ-012 The block SHALL be a three-state FSM: IDLE, SORT, DONE.
REQ-013 IDLE: in_rdy=1, out_val=0; on in_val&&in_rdy, latch in_msg into element registers and in_mode into a mode register, clear phase counter, go to SORT.
REQ-014 SORT: in_rdy=0, out_val=0; each cycle performs one odd-even transposition phase on the element registers, then increments the phase counter.
REQ-015 Even phase (counter even) SHALL compare-exchange pairs (0,1),(2,3),...; odd phase SHALL compare-exchange pairs (1,2),(3,4),...,(p_nelems-3,p_nelems-2); elements 0 and p_nelems-1 hold in odd phases.
REQ-016 Compare-exchange: ascending places the smaller value at the lower index; descending places the larger value at the lower index.
REQ-017 Comparison SHALL be unsigned over p_nbits; equal values SHALL NOT swap.
REQ-018 After exactly p_nelems phases (counter reaching p_nelems-1 in SORT), the FSM SHALL go to DONE.
REQ-019 DONE: out_val=1, in_rdy=0, out_msg = element registers, held stable; on out_rdy=1 go to IDLE next cycle.
REQ-020 Latency: if a message is accepted in cycle T, out_val SHALL first assert in cycle T+p_nelems+1; fixed, data-independent.
REQ-021 Throughput: a new message SHALL NOT be accepted in the DONE handoff cycle; earliest next accept is the cycle after handoff (one message per p_nelems+2 cycles).
REQ-022 in_mode and in_msg changes outside the IDLE accept cycle SHALL have no effect.
REQ-023 out_msg is unconstrained but deterministic (current registers) when out_val=0.
REQ-024 Phase counter width SHALL be $clog2(p_nelems), minimum 1 bit.

Reset
REQ-025 reset assertion SHALL immediately (without clock) force state IDLE, in_rdy=1, out_val=0, element registers=0, mode=0, phase counter=0.
REQ-026 reset mid-SORT or mid-DONE SHALL abort the message; no partial result is ever presented with out_val=1.
REQ-027 On the first rising edge after reset deassertion, the block SHALL accept a message if in_val=1.

Structure
REQ-028 A shared package iter_sort_pkg SHALL hold the FSM state enum (IDLE/SORT/DONE) and the mode constants (ASCEND=0, DESCEND=1).
REQ-029 One sub-module cmp_swap_unit (parameter p_nbits; inputs in0, in1, mode; outputs out_lo, out_hi, combinational) SHALL implement REQ-016/017 and be instantiated p_nelems/2 times for even and p_nelems/2-1 times for odd phases.
REQ-030 All sequential logic SHALL reside in the top module; cmp_swap_unit SHALL be purely combinational.

Verification (p_nbits=8, p_nelems=4)
REQ-031 Accept {e0..e3}={3,1,4,2}, mode 0, out_rdy=1 -> out_val high exactly 5 cycles after accept, out_msg {1,2,3,4}.
REQ-032 Same input, mode 1 -> out_msg {4,3,2,1}.
REQ-033 Input {255,0,255,0} mode 0 -> {0,0,255,255}; input {7,7,7,7} -> {7,7,7,7} unchanged.
REQ-034 out_rdy=0 for 3 cycles in DONE -> out_val stays 1, out_msg stable, in_rdy stays 0; out_rdy=1 -> next cycle IDLE, in_rdy=1.
REQ-035 reset asserted during SORT phase 2 -> out_val=0, in_rdy=1 before next clock edge; next accepted {9,8,7,6} mode 0 yields {6,7,8,9}.
REQ-036 in_val held high with two queued messages, out_rdy=1 -> second accepted the cycle after first handoff; both results correct and in order.
